// File: rtl/bp_be_pkg.sv
// Shared types for the backend stride detector: config enum, FSM states, table entry.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg
  } bp_params_e;

  localparam int bp_vaddr_width_gp        = 39;
  // Stored strides are kept sign-extended to this width; stride_width_p must not exceed it.
  localparam int bp_stride_store_width_gp = 32;

  function automatic int bp_vaddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_vaddr_width_gp;
      default:          return bp_vaddr_width_gp;
    endcase
  endfunction

  typedef enum logic [1:0] {
    e_stride_idle,
    e_stride_discover,
    e_stride_locked
  } bp_be_stride_state_e;

  typedef struct packed {
    logic                                valid;
    logic [bp_vaddr_width_gp-1:0]        pc;
    logic [bp_vaddr_width_gp-1:0]        last_addr;
    logic [bp_stride_store_width_gp-1:0] stride;
    logic [1:0]                          conf;
  } bp_be_stride_entry_s;

endpackage

// File: rtl/bp_be_stride_table.sv
// Fully associative PC-indexed stride table with round-robin replacement.
// Optional BP_BE_STRIDE_NEG_EN: negative address deltas are accepted as strides.
module bp_be_stride_table
  import bp_be_pkg::*;
#(
  parameter int  stride_els_p   = 8,
  parameter int  stride_width_p = 16,
  localparam int idx_width_lp   = $clog2(stride_els_p),
  localparam int vaddr_width_lp = bp_vaddr_width_gp
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_v,
  input  logic [vaddr_width_lp-1:0] i_pc,
  input  logic [vaddr_width_lp-1:0] i_vaddr,
  input  logic                      i_skip_v,
  input  logic [idx_width_lp-1:0]   i_skip_idx,
  output logic                      o_hit,
  output logic [idx_width_lp-1:0]   o_hit_idx,
  output logic                      o_stride_match,
  output logic [1:0]                o_conf_new,
  output logic [stride_width_p-1:0] o_stride
);

  bp_be_stride_entry_s r_tbl [stride_els_p];
  logic [idx_width_lp-1:0] r_ptr;

  logic                                       w_hit;
  logic [idx_width_lp-1:0]                    w_hit_idx;
  logic [idx_width_lp-1:0]                    w_victim;
  bp_be_stride_entry_s                        w_ent;
  logic [vaddr_width_lp-1:0]                  w_delta;
  logic [vaddr_width_lp-stride_width_p:0]     w_delta_hi;
  logic signed [bp_stride_store_width_gp-1:0] w_delta_sx;
  logic signed [bp_stride_store_width_gp-1:0] w_stride_new;
  logic                                       w_fits;
  logic                                       w_match;
  logic [1:0]                                 w_conf_new;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < stride_els_p; i++) begin
      if (r_tbl[i].valid && (r_tbl[i].pc == i_pc)) begin
        w_hit     = 1'b1;
        w_hit_idx = i[idx_width_lp-1:0];
      end
    end
  end

  always_comb begin
    w_ent      = r_tbl[w_hit_idx];
    w_delta    = i_vaddr - w_ent.last_addr;
    w_delta_hi = w_delta[vaddr_width_lp-1:stride_width_p-1];
`ifdef BP_BE_STRIDE_NEG_EN
    w_fits     = (&w_delta_hi) | ~(|w_delta_hi);
`else
    w_fits     = ~(|w_delta_hi);
`endif
    w_delta_sx   = bp_stride_store_width_gp'($signed(w_delta[stride_width_p-1:0]));
    w_match      = (w_delta != '0) && w_fits && (w_delta_sx == $signed(w_ent.stride));
    w_stride_new = w_fits ? w_delta_sx : '0;
    w_conf_new   = w_match ? ((w_ent.conf == 2'd3) ? 2'd3 : w_ent.conf + 2'd1) : 2'd0;
    // The FSM's tracked entry must survive until discovery finishes.
    w_victim     = (i_skip_v && (r_ptr == i_skip_idx)) ? r_ptr + idx_width_lp'(1) : r_ptr;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
      for (int i = 0; i < stride_els_p; i++) r_tbl[i] <= '0;
    end else if (i_v) begin
      if (w_hit) begin
        r_tbl[w_hit_idx].last_addr <= i_vaddr;
        r_tbl[w_hit_idx].conf      <= w_conf_new;
        if (!w_match) r_tbl[w_hit_idx].stride <= w_stride_new;
      end else begin
        r_tbl[w_victim] <= '{valid: 1'b1, pc: i_pc, last_addr: i_vaddr, stride: '0, conf: 2'd0};
        r_ptr           <= w_victim + idx_width_lp'(1);
      end
    end
  end

  assign o_hit          = i_v & w_hit;
  assign o_hit_idx      = w_hit_idx;
  assign o_stride_match = w_match;
  assign o_conf_new     = w_conf_new;
  assign o_stride       = w_ent.stride[stride_width_p-1:0];

endmodule

// File: rtl/bp_be_stride_detector.sv
// Detects constant-stride committed loads and sequences loop discovery for one tracked PC.
// Negative-stride support is enabled by defining BP_BE_STRIDE_NEG_EN.
//   state    | meaning
//   IDLE     | no PC tracked; first entry to reach start_thresh_p starts discovery
//   DISCOVER | tracking one entry; saturation confirms, stride mismatch abandons
//   LOCKED   | confirmed; waits for discovery_done_i
module bp_be_stride_detector
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p    = e_bp_default_cfg,
  parameter int         stride_els_p   = 8,
  parameter int         stride_width_p = 16,
  parameter int         start_thresh_p = 2,
  localparam int        vaddr_width_p  = bp_vaddr_width(bp_params_p),
  localparam int        idx_width_lp   = $clog2(stride_els_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  vaddr_i,
  input  logic                      discovery_done_i,
  output logic                      start_discovery_o,
  output logic                      confirm_discovery_o,
  output logic [vaddr_width_p-1:0]  striding_pc_o,
  output logic [stride_width_p-1:0] stride_o
);

  localparam logic [1:0] conf_sat_lp   = 2'd3;
  localparam logic [1:0] conf_start_lp = 2'(start_thresh_p);

  bp_be_stride_state_e       r_state, w_state_n;
  logic [idx_width_lp-1:0]   r_track_idx;
  logic                      r_start, r_confirm;
  logic [vaddr_width_p-1:0]  r_pc;
  logic [stride_width_p-1:0] r_stride;

  logic                      w_hit, w_match, w_start_n, w_confirm_n, w_latch;
  logic [idx_width_lp-1:0]   w_hit_idx;
  logic [1:0]                w_conf_new;
  logic [stride_width_p-1:0] w_hit_stride;

  bp_be_stride_table #(
    .stride_els_p  (stride_els_p),
    .stride_width_p(stride_width_p)
  ) u_table (
    .i_clk         (clk_i),
    .i_rst         (reset_i),
    .i_v           (v_i),
    .i_pc          (pc_i),
    .i_vaddr       (vaddr_i),
    .i_skip_v      (r_state != e_stride_idle),
    .i_skip_idx    (r_track_idx),
    .o_hit         (w_hit),
    .o_hit_idx     (w_hit_idx),
    .o_stride_match(w_match),
    .o_conf_new    (w_conf_new),
    .o_stride      (w_hit_stride)
  );

  always_comb begin
    w_state_n   = r_state;
    w_start_n   = 1'b0;
    w_confirm_n = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      e_stride_idle: begin
        if (w_hit && w_match && (w_conf_new == conf_start_lp)) begin
          w_state_n = e_stride_discover;
          w_start_n = 1'b1;
          w_latch   = 1'b1;
        end
      end
      e_stride_discover: begin
        if (w_hit && (w_hit_idx == r_track_idx)) begin
          if (!w_match) begin
            w_state_n = e_stride_idle;
          end else if (w_conf_new == conf_sat_lp) begin
            w_state_n   = e_stride_locked;
            w_confirm_n = 1'b1;
          end
        end
      end
      e_stride_locked: begin
        if (discovery_done_i) w_state_n = e_stride_idle;
      end
      default: w_state_n = e_stride_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= e_stride_idle;
      r_track_idx <= '0;
      r_start     <= 1'b0;
      r_confirm   <= 1'b0;
      r_pc        <= '0;
      r_stride    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_start   <= w_start_n;
      r_confirm <= w_confirm_n;
      if (w_latch) begin
        r_track_idx <= w_hit_idx;
        r_pc        <= pc_i;
        r_stride    <= w_hit_stride;
      end
    end
  end

  assign start_discovery_o   = r_start;
  assign confirm_discovery_o = r_confirm;
  assign striding_pc_o       = r_pc;
  assign stride_o            = r_stride;

endmodule
